// File: rtl/wb_burst_responder_pkg.sv
// Shared Wishbone core-bus definitions: bus widths, burst beat counts and
// the responder state encoding. Used by both responder and master side.
package wb_burst_responder_pkg;

  localparam int WB_DATA_W   = 16;
  localparam int WB_ADDR_W   = 24;
  localparam int WB_SEL_BITS = 2;

  localparam logic [3:0] BURST_1 = 4'd1;
  localparam logic [3:0] BURST_4 = 4'd4;
  localparam logic [3:0] BURST_8 = 4'd8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } wb_state_e;

  // Beat count from the burst qualifiers; the 8-beat flag has priority.
  function automatic logic [3:0] burst_beats(input logic b4, input logic b8);
    if (b8) begin
      return BURST_8;
    end else if (b4) begin
      return BURST_4;
    end
    return BURST_1;
  endfunction

endpackage

// File: rtl/wb_burst_responder_store.sv
// Word store behind the responder: byte-masked synchronous write port and
// a combinational read port so the top can register read data itself.
module wb_burst_responder_store
  import wb_burst_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                   i_clk,
  input  logic                   i_we,
  input  logic [DEPTH_LOG2-1:0]  i_waddr,
  input  logic [WB_DATA_W-1:0]   i_wdat,
  input  logic [WB_SEL_BITS-1:0] i_wsel,
  input  logic [DEPTH_LOG2-1:0]  i_raddr,
  output logic [WB_DATA_W-1:0]   o_rdat
);

  logic [WB_SEL_BITS-1:0][7:0] mem_q [2**DEPTH_LOG2];

  // Byte-lane write: only lanes with their select bit set are updated.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < WB_SEL_BITS; b++) begin
        if (i_wsel[b]) begin
          mem_q[i_waddr][b] <= i_wdat[b*8 +: 8];
        end
      end
    end
  end

  // Combinational read; the top captures this into its output register.
  always_comb begin
    o_rdat = mem_q[i_raddr];
  end

endmodule

// File: rtl/wb_burst_responder.sv
// Wishbone burst responder: accepts single, 4- and 8-beat transfers,
// produces one registered ack/err per beat with per-beat range checking,
// and serves reads/writes from a small internal word store.
module wb_burst_responder
  import wb_burst_responder_pkg::*;
#(
  parameter logic [WB_ADDR_W-1:0] BASE_ADDR  = 24'h002000,
  parameter int                   DEPTH_LOG2 = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wb_cyc,
  input  logic                   i_wb_stb,
  input  logic                   i_wb_we,
  input  logic [WB_ADDR_W-1:0]   i_wb_adr,
  input  logic [WB_DATA_W-1:0]   i_wb_dat,
  input  logic [WB_SEL_BITS-1:0] i_wb_sel,
  input  logic                   i_wb_4_burst,
  input  logic                   i_wb_8_burst,
  output logic                   o_wb_ack,
  output logic                   o_wb_err,
  output logic [WB_DATA_W-1:0]   o_wb_dat,
  output logic                   o_busy
);

  wb_state_e            state_q, state_d;
  logic [WB_ADDR_W-1:0] beat_adr_q, beat_adr_d;
  logic                 we_q, we_d;
  logic [3:0]           beats_q, beats_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [WB_DATA_W-1:0] dat_q, dat_d;

  // The "probe" address is the beat whose response is prepared this cycle
  // and registered at the coming edge: the request address in IDLE, the
  // next sequential beat in RESP.
  logic [WB_ADDR_W-1:0]  probe_adr;
  logic [WB_ADDR_W-1:0]  probe_off;
  logic                  probe_in_range;
  logic [DEPTH_LOG2-1:0] cur_idx;
  logic [WB_DATA_W-1:0]  rd_data;
  logic                  wr_en;

  // Address generation, range check and write qualification.
  always_comb begin
    probe_adr      = (state_q == ST_IDLE) ? i_wb_adr : beat_adr_q + 24'd1;
    probe_off      = probe_adr - BASE_ADDR;
    // Unsigned offset test covers both the lower and upper bound at once.
    probe_in_range = ((probe_off >> DEPTH_LOG2) == '0);
    cur_idx        = beat_adr_q[DEPTH_LOG2-1:0] - BASE_ADDR[DEPTH_LOG2-1:0];
    // A write commits only at the end of an ack cycle that was not aborted.
    wr_en          = (state_q == ST_RESP) && i_wb_cyc && ack_q && we_q;
  end

  wb_burst_responder_store #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_store (
    .i_clk  (i_clk),
    .i_we   (wr_en),
    .i_waddr(cur_idx),
    .i_wdat (i_wb_dat),
    .i_wsel (i_wb_sel),
    .i_raddr(probe_off[DEPTH_LOG2-1:0]),
    .o_rdat (rd_data)
  );

  // FSM next state: accept in IDLE, step through beats in RESP, abort on cyc low.
  always_comb begin
    state_d    = state_q;
    beat_adr_d = beat_adr_q;
    we_d       = we_q;
    beats_d    = beats_q;
    cnt_d      = cnt_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    dat_d      = '0;
    case (state_q)
      ST_IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          state_d    = ST_RESP;
          beat_adr_d = i_wb_adr;
          we_d       = i_wb_we;
          beats_d    = burst_beats(i_wb_4_burst, i_wb_8_burst);
          cnt_d      = 4'd0;
          ack_d      = probe_in_range;
          err_d      = !probe_in_range;
          dat_d      = (probe_in_range && !i_wb_we) ? rd_data : '0;
        end
      end
      ST_RESP: begin
        if (!i_wb_cyc || (cnt_q == beats_q - 4'd1)) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d      = cnt_q + 4'd1;
          beat_adr_d = probe_adr;
          ack_d      = probe_in_range;
          err_d      = !probe_in_range;
          dat_d      = (probe_in_range && !we_q) ? rd_data : '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered response outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      beat_adr_q <= '0;
      we_q       <= 1'b0;
      beats_q    <= BURST_1;
      cnt_q      <= 4'd0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      state_q    <= state_d;
      beat_adr_q <= beat_adr_d;
      we_q       <= we_d;
      beats_q    <= beats_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      dat_q      <= dat_d;
    end
  end

  // Outputs are registered; only the abort path gates them with live cyc.
  always_comb begin
    o_wb_ack = ack_q && i_wb_cyc;
    o_wb_err = err_q && i_wb_cyc;
    o_wb_dat = i_wb_cyc ? dat_q : '0;
    o_busy   = (state_q == ST_RESP);
  end

endmodule

// File: tb/tb_wb_burst_responder.sv
// Scoreboard bench for wb_burst_responder: stimulus pushes expected beat
// responses, a negedge monitor pops and compares each ack/err it sees.
module tb_wb_burst_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we_s, b4, b8;
  logic [23:0] adr_s;
  logic [15:0] wdat;
  logic [1:0]  sel_s;
  logic        ack, err, busy;
  logic [15:0] rdat;

  always #5 clk = ~clk;

  wb_burst_responder #(
    .BASE_ADDR (24'h002000),
    .DEPTH_LOG2(5)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wb_cyc    (cyc),
    .i_wb_stb    (stb),
    .i_wb_we     (we_s),
    .i_wb_adr    (adr_s),
    .i_wb_dat    (wdat),
    .i_wb_sel    (sel_s),
    .i_wb_4_burst(b4),
    .i_wb_8_burst(b8),
    .o_wb_ack    (ack),
    .o_wb_err    (err),
    .o_wb_dat    (rdat),
    .o_busy      (busy)
  );

  typedef struct {
    logic        ack;
    logic        err;
    logic [15:0] dat;
    logic        chk_dat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [15:0] wdata [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, req);
  endtask

  task automatic expect_beat(input logic is_ack, input logic [15:0] dat, input logic chk);
    exp_t e;
    e.ack = is_ack; e.err = !is_ack; e.dat = dat; e.chk_dat = chk;
    exp_q.push_back(e);
  endtask

  // Monitor: every presented response must match the next expected beat.
  always @(negedge clk) begin
    if (!rst && (ack || err)) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_resp: actual ack=%b err=%b dat=%h required no response", ack, err, rdat);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_ack", {31'd0, ack}, {31'd0, e.ack});
        check("resp_err", {31'd0, err}, {31'd0, e.err});
        if (e.chk_dat) check("resp_dat", {16'd0, rdat}, {16'd0, e.dat});
      end
    end
  end

  // One bus transfer. abort_at / rst_at pick a beat to drop cyc or pulse reset in (-1 = none).
  task automatic xfer(input logic we, input logic [23:0] adr, input int nbeats,
                      input logic both_flags, input logic [1:0] sel,
                      input int abort_at, input int rst_at);
    bit early;
    early = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we_s = we; adr_s = adr; wdat = wdata[0]; sel_s = sel;
    b8 = (nbeats == 8);
    b4 = (nbeats == 4) || both_flags;
    @(posedge clk); #1;
    stb = 0; b4 = 0; b8 = 0;
    for (int k = 0; k < nbeats; k++) begin
      wdat = wdata[k];
      if (k == abort_at) begin
        cyc = 0;
        #1;
        check("abort_ack", {31'd0, ack}, 32'd0);
        check("abort_err", {31'd0, err}, 32'd0);
        @(posedge clk); #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        early = 1;
        break;
      end
      if (k == rst_at) begin
        #1; rst = 1; #1;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 0; cyc = 0;
        early = 1;
        break;
      end
      check("beat_present", {31'd0, ack | err}, 32'd1);
      check("beat_onehot", {31'd0, ack & err}, 32'd0);
      @(posedge clk); #1;
    end
    if (!early) begin
      check("busy_after", {31'd0, busy}, 32'd0);
      cyc = 0;
    end
  endtask

  task automatic rd1(input logic [23:0] adr, input logic ok, input logic [15:0] dat);
    expect_beat(ok, dat, 1'b1);
    xfer(1'b0, adr, 1, 1'b0, 2'b11, -1, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; cyc = 0; stb = 0; we_s = 0; b4 = 0; b8 = 0;
    adr_s = '0; wdat = '0; sel_s = '0;
    for (int i = 0; i < 8; i++) wdata[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", {31'd0, ack}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_dat", {16'd0, rdat}, 32'd0);
    @(negedge clk); rst = 0;

    // Single write then read back.
    wdata[0] = 16'hBEEF;
    expect_beat(1, 16'h0, 0);
    xfer(1'b1, 24'h002003, 1, 1'b0, 2'b11, -1, -1);
    rd1(24'h002003, 1, 16'hBEEF);

    // Low-byte-only write.
    wdata[0] = 16'h1234;
    expect_beat(1, 16'h0, 0);
    xfer(1'b1, 24'h002003, 1, 1'b0, 2'b01, -1, -1);
    rd1(24'h002003, 1, 16'hBE34);

    // Preload words 0..7 with an 8-beat write, read back with both flags set.
    for (int k = 0; k < 8; k++) begin
      wdata[k] = 16'h0100 + 16'(k);
      expect_beat(1, 16'h0, 0);
    end
    xfer(1'b1, 24'h002000, 8, 1'b0, 2'b11, -1, -1);
    for (int k = 0; k < 8; k++) expect_beat(1, 16'h0100 + 16'(k), 1);
    xfer(1'b0, 24'h002000, 8, 1'b1, 2'b11, -1, -1);

    // 4-beat write straddling the top of the range.
    wdata[0] = 16'hAAAA; wdata[1] = 16'hBBBB; wdata[2] = 16'hCCCC; wdata[3] = 16'hDDDD;
    expect_beat(1, 16'h0, 0); expect_beat(1, 16'h0, 0);
    expect_beat(0, 16'h0, 1); expect_beat(0, 16'h0, 1);
    xfer(1'b1, 24'h00201E, 4, 1'b0, 2'b11, -1, -1);
    rd1(24'h002000, 1, 16'h0100);
    rd1(24'h002001, 1, 16'h0101);
    rd1(24'h00201E, 1, 16'hAAAA);
    rd1(24'h00201F, 1, 16'hBBBB);
    rd1(24'h002020, 0, 16'h0000);
    rd1(24'h001FFF, 0, 16'h0000);

    // 8-beat read aborted in beat 3, then an immediate single read.
    for (int k = 0; k < 3; k++) expect_beat(1, 16'h0100 + 16'(k), 1);
    xfer(1'b0, 24'h002000, 8, 1'b0, 2'b11, 3, -1);
    rd1(24'h002004, 1, 16'h0104);

    // Preload words 8..15, then a 4-beat write hit by reset in beat 2.
    for (int k = 0; k < 8; k++) begin
      wdata[k] = 16'h0208 + 16'(k);
      expect_beat(1, 16'h0, 0);
    end
    xfer(1'b1, 24'h002008, 8, 1'b0, 2'b11, -1, -1);
    for (int k = 0; k < 4; k++) wdata[k] = 16'h5550 + 16'(k);
    expect_beat(1, 16'h0, 0); expect_beat(1, 16'h0, 0);
    xfer(1'b1, 24'h002008, 4, 1'b0, 2'b11, -1, 2);
    for (int k = 0; k < 4; k++) wdata[k] = 16'h0;
    expect_beat(1, 16'h5550, 1); expect_beat(1, 16'h5551, 1);
    expect_beat(1, 16'h020A, 1); expect_beat(1, 16'h020B, 1);
    xfer(1'b0, 24'h002008, 4, 1'b0, 2'b11, -1, -1);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
